// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: fetch, decode, execute, memory and write-back all
// complete within one clock, with on-chip instruction ROM and data RAM.
module rv32i_single_cycle_core #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter string       IMEM_INIT  = "program.hex",
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] ALU_Output,
    output logic [31:0] PC_out
);

    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] regs [32];

    logic [31:0] pc, next_pc, pc_plus4, instr;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [4:0]  shamt;
    alu_op_e     alu_op;
    wb_sel_e     wb_sel;
    logic        reg_we, mem_we, is_jump, is_branch, branch_cond;
    logic [IMEM_AW-1:0] imem_idx;
    logic [DMEM_AW-1:0] dmem_idx;
    logic [31:0] mem_word, load_data, store_data, wb_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [3:0]  byte_en;

    // Power-up memory contents: unused ROM words decode as NOP, RAM starts zeroed.
    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) imem[i] = 32'h0000_0013;
        for (int i = 0; i < DMEM_WORDS; i++) dmem[i] = '0;
    end

    assign imem_idx = IMEM_AW'({2'b00, pc[31:2]} % 32'(IMEM_WORDS));
    assign instr    = imem[imem_idx];
    assign pc_plus4 = pc + 32'd4;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // alt selects SUB/SRA; only meaningful for the funct3 codes that have a variant
    function automatic alu_op_e alu_op_from(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        alu_a     = rs1_val;
        alu_b     = imm_i;
        alu_op    = ALU_ADD;
        wb_sel    = WB_ALU;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        is_jump   = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_b  = imm_u;
                alu_op = ALU_PASS_B;
                reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a  = pc;
                alu_b  = imm_u;
                reg_we = 1'b1;
            end
            OPC_JAL: begin
                alu_a   = pc;
                alu_b   = imm_j;
                wb_sel  = WB_PC4;
                reg_we  = 1'b1;
                is_jump = 1'b1;
            end
            OPC_JALR: begin
                wb_sel  = WB_PC4;
                reg_we  = (funct3 == 3'b000);
                is_jump = (funct3 == 3'b000);
            end
            OPC_BRANCH: begin
                alu_b     = rs2_val;
                alu_op    = ALU_SUB;
                is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_LOAD: begin
                wb_sel = WB_MEM;
                reg_we = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OPC_STORE: begin
                alu_b  = imm_s;
                mem_we = funct3 inside {3'b000, 3'b001, 3'b010};
            end
            OPC_OP_IMM: begin
                alu_op = alu_op_from(funct3, funct7[5] && (funct3 == 3'b101));
                if (funct3 == 3'b001)      reg_we = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101) reg_we = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else                       reg_we = 1'b1;
            end
            OPC_OP: begin
                alu_b  = rs2_val;
                alu_op = alu_op_from(funct3, funct7[5]);
                reg_we = (funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            default: ;
        endcase
    end

    assign shamt = alu_b[4:0];

    always_comb begin
        case (alu_op)
            ALU_ADD:    alu_result = alu_a + alu_b;
            ALU_SUB:    alu_result = alu_a - alu_b;
            ALU_SLL:    alu_result = alu_a << shamt;
            ALU_SLT:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:   alu_result = {31'd0, alu_a < alu_b};
            ALU_XOR:    alu_result = alu_a ^ alu_b;
            ALU_SRL:    alu_result = alu_a >> shamt;
            ALU_SRA:    alu_result = 32'($signed(alu_a) >>> shamt);
            ALU_OR:     alu_result = alu_a | alu_b;
            ALU_AND:    alu_result = alu_a & alu_b;
            ALU_PASS_B: alu_result = alu_b;
            default:    alu_result = alu_a + alu_b;
        endcase
    end

    // The comparator works on the raw operands; the ALU difference is for observation only.
    always_comb begin
        case (funct3)
            3'b000:  branch_cond = (rs1_val == rs2_val);
            3'b001:  branch_cond = (rs1_val != rs2_val);
            3'b100:  branch_cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  branch_cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  branch_cond = (rs1_val <  rs2_val);
            3'b111:  branch_cond = (rs1_val >= rs2_val);
            default: branch_cond = 1'b0;
        endcase
    end

    always_comb begin
        if (is_jump)
            next_pc = (opcode == OPC_JALR) ? (alu_result & ~32'd1) : alu_result;
        else if (is_branch && branch_cond)
            next_pc = pc + imm_b;
        else
            next_pc = pc_plus4;
    end

    assign dmem_idx  = DMEM_AW'({2'b00, alu_result[31:2]} % 32'(DMEM_WORDS));
    assign mem_word  = dmem[dmem_idx];
    assign load_byte = mem_word[8*alu_result[1:0] +: 8];
    assign load_half = alu_result[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        case (funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b100:  load_data = {24'd0, load_byte};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = mem_word;
        endcase
    end

    // Store data is replicated across lanes; byte_en picks which lanes commit.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << alu_result[1:0];
                store_data = {4{rs2_val[7:0]}};
            end
            2'b01: begin
                byte_en    = alu_result[1] ? 4'b1100 : 4'b0011;
                store_data = {2{rs2_val[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = rs2_val;
            end
        endcase
    end

    always_comb begin
        case (wb_sel)
            WB_MEM:  wb_data = load_data;
            WB_PC4:  wb_data = pc_plus4;
            default: wb_data = alu_result;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    // NOTE: the register file is flops and is cleared on reset; the data RAM has no reset so it maps to memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            pc <= next_pc;
            if (reg_we && (rd != 5'd0)) regs[rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b]) dmem[dmem_idx][8*b +: 8] <= store_data[8*b +: 8];
        end
    end

    assign ALU_Output = alu_result;
    assign PC_out     = pc;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed bench for rv32i_single_cycle_core: small programs are placed in the ROM
// and the PC/ALU trace is compared against hand-computed tables.
module tb_rv32i_single_cycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] alu_output;
    logic [31:0] pc_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        bit          chk_alu;
    } step_t;

    step_t trace[$];

    rv32i_single_cycle_core #(
        .IMEM_WORDS(256),
        .DMEM_WORDS(256),
        .IMEM_INIT(""),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ALU_Output(alu_output),
        .PC_out(pc_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'h13);
    endfunction

    function automatic logic [31:0] opi(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [31:0] imm);
        return enc_i(imm, rs1, f3, rd, 7'h13);
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] load(input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [31:0] imm);
        return enc_i(imm, rs1, f3, rd, 7'h03);
    endfunction

    function automatic logic [31:0] store(input logic [2:0] f3, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] branch(input logic [2:0] f3, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] imm20);
        return {imm20[19:0], rd, op};
    endfunction

    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'h67);
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) dut.imem[8'(i)] = 32'h0000_0013;
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] ins);
        logic [7:0] idx;
        idx = addr[9:2];
        dut.imem[idx] = ins;
    endtask

    task automatic add(input logic [31:0] pc, input logic [31:0] alu, input bit chk_alu);
        step_t s;
        s.pc = pc;
        s.alu = alu;
        s.chk_alu = chk_alu;
        trace.push_back(s);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " reset pc"}, pc_out, 32'h0);
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_trace(input string tag);
        foreach (trace[i]) begin
            check($sformatf("%s step%0d pc", tag, i), pc_out, trace[i].pc);
            if (trace[i].chk_alu)
                check($sformatf("%s step%0d alu", tag, i), alu_output, trace[i].alu);
            step();
        end
        trace.delete();
    endtask

    initial begin
        #1;

        // NOP program: PC walks 0, 4, 8
        clear_rom();
        do_reset("nop");
        add(32'h0, 32'h0, 1); add(32'h4, 32'h0, 1); add(32'h8, 32'h0, 1);
        run_trace("nop");

        // Arithmetic and logic
        clear_rom();
        put(32'h00, addi(1, 0, 5));
        put(32'h04, addi(2, 0, -3));
        put(32'h08, enc_r(7'h00, 3'b000, 3, 1, 2));
        put(32'h0C, enc_r(7'h20, 3'b000, 4, 1, 2));
        put(32'h10, opi(3'b101, 5, 2, 32'h401));
        put(32'h14, enc_r(7'h00, 3'b010, 6, 2, 1));
        put(32'h18, enc_r(7'h00, 3'b011, 6, 2, 1));
        put(32'h1C, opi(3'b101, 7, 2, 28));
        put(32'h20, opi(3'b001, 8, 1, 3));
        put(32'h24, opi(3'b100, 9, 1, -1));
        put(32'h28, opi(3'b110, 10, 1, 32'hF0));
        put(32'h2C, opi(3'b111, 11, 2, 32'hFF));
        put(32'h30, opi(3'b011, 12, 1, -1));
        put(32'h34, enc_r(7'h20, 3'b101, 13, 2, 1));
        put(32'h38, enc_r(7'h00, 3'b001, 14, 1, 1));
        put(32'h3C, enc_r(7'h00, 3'b101, 15, 2, 1));
        put(32'h40, enc_r(7'h00, 3'b111, 16, 1, 2));
        put(32'h44, enc_r(7'h00, 3'b110, 17, 1, 2));
        put(32'h48, enc_r(7'h00, 3'b100, 18, 1, 2));
        put(32'h4C, opi(3'b010, 19, 2, -2));
        put(32'h50, enc_r(7'h00, 3'b000, 0, 12, 14));
        put(32'h54, addi(20, 0, 32'h400));
        do_reset("arith");
        add(32'h00, 32'h0000_0005, 1); add(32'h04, 32'hFFFF_FFFD, 1);
        add(32'h08, 32'h0000_0002, 1); add(32'h0C, 32'h0000_0008, 1);
        add(32'h10, 32'hFFFF_FFFE, 1); add(32'h14, 32'h0000_0001, 1);
        add(32'h18, 32'h0000_0000, 1); add(32'h1C, 32'h0000_000F, 1);
        add(32'h20, 32'h0000_0028, 1); add(32'h24, 32'hFFFF_FFFA, 1);
        add(32'h28, 32'h0000_00F5, 1); add(32'h2C, 32'h0000_00FD, 1);
        add(32'h30, 32'h0000_0001, 1); add(32'h34, 32'hFFFF_FFFF, 1);
        add(32'h38, 32'h0000_00A0, 1); add(32'h3C, 32'h07FF_FFFF, 1);
        add(32'h40, 32'h0000_0005, 1); add(32'h44, 32'hFFFF_FFFD, 1);
        add(32'h48, 32'hFFFF_FFF8, 1); add(32'h4C, 32'h0000_0001, 1);
        add(32'h50, 32'h0000_00A1, 1); add(32'h54, 32'h0000_0400, 1);
        run_trace("arith");

        // Loads and stores, including lane selection and misaligned word access
        clear_rom();
        put(32'h00, addi(1, 0, 32'h40));
        put(32'h04, addi(2, 0, -1));
        put(32'h08, store(3'b000, 2, 1, 1));
        put(32'h0C, load(3'b010, 3, 1, 0));
        put(32'h10, load(3'b100, 4, 1, 1));
        put(32'h14, enc_r(7'h00, 3'b000, 0, 3, 0));
        put(32'h18, enc_r(7'h00, 3'b000, 0, 4, 0));
        put(32'h1C, load(3'b000, 5, 1, 1));
        put(32'h20, enc_r(7'h00, 3'b000, 0, 5, 0));
        put(32'h24, store(3'b001, 1, 1, 2));
        put(32'h28, load(3'b010, 6, 1, 0));
        put(32'h2C, enc_r(7'h00, 3'b000, 0, 6, 0));
        put(32'h30, load(3'b001, 7, 1, 2));
        put(32'h34, enc_r(7'h00, 3'b000, 0, 7, 0));
        put(32'h38, load(3'b001, 8, 1, 0));
        put(32'h3C, enc_r(7'h00, 3'b000, 0, 8, 0));
        put(32'h40, store(3'b010, 2, 1, 4));
        put(32'h44, load(3'b101, 9, 1, 6));
        put(32'h48, enc_r(7'h00, 3'b000, 0, 9, 0));
        put(32'h4C, load(3'b010, 10, 1, 3));
        put(32'h50, enc_r(7'h00, 3'b000, 0, 10, 0));
        do_reset("mem");
        add(32'h00, 32'h0000_0040, 1); add(32'h04, 32'hFFFF_FFFF, 1);
        add(32'h08, 32'h0000_0041, 1); add(32'h0C, 32'h0000_0040, 1);
        add(32'h10, 32'h0000_0041, 1); add(32'h14, 32'h0000_FF00, 1);
        add(32'h18, 32'h0000_00FF, 1); add(32'h1C, 32'h0000_0041, 1);
        add(32'h20, 32'hFFFF_FFFF, 1); add(32'h24, 32'h0000_0042, 1);
        add(32'h28, 32'h0000_0040, 1); add(32'h2C, 32'h0040_FF00, 1);
        add(32'h30, 32'h0000_0042, 1); add(32'h34, 32'h0000_0040, 1);
        add(32'h38, 32'h0000_0040, 1); add(32'h3C, 32'hFFFF_FF00, 1);
        add(32'h40, 32'h0000_0044, 1); add(32'h44, 32'h0000_0046, 1);
        add(32'h48, 32'h0000_FFFF, 1); add(32'h4C, 32'h0000_0043, 1);
        add(32'h50, 32'h0040_FF00, 1);
        run_trace("mem");

        // Control flow, U-type, x0 and NOP-class instructions; unreached slots poison x31
        clear_rom();
        foreach (trace[i]) trace.delete(i);
        for (int a = 0; a < 32'h90; a += 4) put(32'(a), addi(31, 0, 99));
        put(32'h00, addi(2, 0, -1));
        put(32'h04, addi(3, 0, 1));
        put(32'h08, enc_u(7'h17, 7, 1));
        put(32'h0C, enc_r(7'h00, 3'b000, 0, 7, 0));
        put(32'h10, branch(3'b000, 0, 0, 8));
        put(32'h18, branch(3'b001, 0, 0, 8));
        put(32'h1C, addi(0, 0, 0));
        put(32'h20, jal(1, 16));
        put(32'h30, enc_r(7'h00, 3'b000, 0, 1, 0));
        put(32'h34, jalr(0, 1, 0));
        put(32'h24, enc_u(7'h37, 0, 32'h12345));
        put(32'h28, enc_u(7'h37, 6, 32'h12345));
        put(32'h2C, jal(0, 32'h14));
        put(32'h40, branch(3'b100, 2, 3, 8));
        put(32'h48, branch(3'b110, 2, 3, 8));
        put(32'h4C, branch(3'b101, 2, 3, 8));
        put(32'h50, branch(3'b111, 2, 3, 8));
        put(32'h58, branch(3'b101, 3, 2, 8));
        put(32'h60, jalr(5, 0, 32'h71));
        put(32'h70, enc_r(7'h00, 3'b000, 0, 5, 0));
        put(32'h74, 32'h0000_0073);
        put(32'h78, 32'hFFFF_FFFF);
        put(32'h7C, enc_r(7'h00, 3'b000, 0, 31, 0));
        put(32'h80, enc_r(7'h00, 3'b000, 0, 0, 6));
        put(32'h84, addi(0, 0, 0));
        do_reset("ctrl");
        add(32'h00, 32'hFFFF_FFFF, 1); add(32'h04, 32'h0000_0001, 1);
        add(32'h08, 32'h0000_1008, 1); add(32'h0C, 32'h0000_1008, 1);
        add(32'h10, 32'h0000_0000, 1); add(32'h18, 32'h0000_0000, 1);
        add(32'h1C, 32'h0000_0000, 1); add(32'h20, 32'h0000_0030, 1);
        add(32'h30, 32'h0000_0024, 1); add(32'h34, 32'h0000_0024, 1);
        add(32'h24, 32'h1234_5000, 1); add(32'h28, 32'h1234_5000, 1);
        add(32'h2C, 32'h0000_0040, 1); add(32'h40, 32'hFFFF_FFFE, 1);
        add(32'h48, 32'hFFFF_FFFE, 1); add(32'h4C, 32'hFFFF_FFFE, 1);
        add(32'h50, 32'hFFFF_FFFE, 1); add(32'h58, 32'h0000_0002, 1);
        add(32'h60, 32'h0000_0000, 0); add(32'h70, 32'h0000_0064, 1);
        add(32'h74, 32'h0000_0000, 0); add(32'h78, 32'h0000_0000, 0);
        add(32'h7C, 32'h0000_0000, 1); add(32'h80, 32'h1234_5000, 1);
        add(32'h84, 32'h0000_0000, 1);
        run_trace("ctrl");

        // Reset asserted while a store is executing: the store must not commit
        clear_rom();
        put(32'h00, addi(1, 0, 32'h80));
        put(32'h04, addi(2, 0, 32'h55));
        put(32'h08, store(3'b010, 2, 1, 0));
        do_reset("midrst");
        step();
        step();
        check("midrst pc before reset", pc_out, 32'h8);
        check("midrst store addr", alu_output, 32'h80);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst pc after reset", pc_out, 32'h0);
        reset = 1'b0;
        clear_rom();
        put(32'h00, load(3'b010, 3, 0, 32'h80));
        put(32'h04, enc_r(7'h00, 3'b000, 0, 3, 0));
        put(32'h08, enc_r(7'h00, 3'b000, 0, 1, 0));
        put(32'h0C, load(3'b010, 4, 0, 32'h40));
        put(32'h10, enc_r(7'h00, 3'b000, 0, 4, 0));
        add(32'h00, 32'h0000_0080, 1); add(32'h04, 32'h0000_0000, 1);
        add(32'h08, 32'h0000_0000, 1); add(32'h0C, 32'h0000_0040, 1);
        add(32'h10, 32'h0040_FF00, 1);
        run_trace("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
